// File: rtl/fetch_pkg.sv
// Shared defaults, FSM state encoding and fetch-queue entry layout for the fetch unit.
// Imported by fetch_unit and fetch_queue.
package fetch_pkg;

    localparam int XLEN_DEF = 32;
    localparam int INSTR_W  = 32;

    localparam logic [XLEN_DEF-1:0] RESET_PC_DEF = 32'h0000_1000;
    localparam logic [XLEN_DEF-1:0] EXC_PC_DEF   = 32'h0000_2000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [INSTR_W-1:0]  instr;
        logic                pred;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry FIFO of fetched instructions; head visible combinationally, one cycle push-to-valid.
// Push is dropped only when full without a simultaneous pop; flush clears everything next edge.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                   clk_i,
    input  logic                   rsn_i,
    input  logic                   push_i,
    input  entry_t                 push_dat_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output entry_t                 head_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    entry_t          r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;

    logic            w_full;
    logic            w_do_pop;
    logic            w_do_push;

    assign w_full    = (r_count == CW'(DEPTH));
    assign empty_o   = (r_count == '0);
    assign w_do_pop  = pop_i && !empty_o;
    // A full queue can still accept when the head leaves in the same cycle.
    assign w_do_push = push_i && (!w_full || w_do_pop);

    assign head_o  = r_mem[r_rptr];
    assign count_o = r_count;

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_do_push && !flush_i) begin
            r_mem[r_wptr] <= push_dat_i;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing with prediction and flushes, one outstanding imem request, DEPTH-entry queue.
// Fetched word reaches decode the cycle after its ack; decode backpressure holds the head and throttles issue.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
    parameter logic [XLEN-1:0] EXC_PC   = EXC_PC_DEF,
    parameter int              DEPTH    = 4
) (
    input  logic            clk_i,
    input  logic            rsn_i,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            exc_i,
    input  logic            iret_i,
    input  logic [XLEN-1:0] exc_ret_pc_i,
    output logic [XLEN-1:0] pc_o,
    input  logic            bp_taken_i,
    input  logic [XLEN-1:0] bp_target_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [31:0]     imem_data_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] out_pc_o,
    output logic [31:0]     out_instr_o,
    output logic            out_pred_o
);

    localparam int              CW         = $clog2(DEPTH) + 1;
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic            pred;
    } entry_t;

    fetch_state_e    r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_bp_taken;
    logic [XLEN-1:0] r_bp_target;

    logic            w_flush;
    logic [XLEN-1:0] w_flush_raw;
    logic [XLEN-1:0] w_flush_pc;
    logic [XLEN-1:0] w_bp_target;
    logic [XLEN-1:0] w_pc_plus4;
    logic            w_outstanding;
    logic            w_has_room;
    logic            w_issue;
    logic            w_push;
    logic            w_pop;
    logic            w_empty;
    logic [CW-1:0]   w_count;
    entry_t          w_push_dat;
    entry_t          w_head;

    assign w_flush     = iret_i || exc_i || redirect_i;
    assign w_flush_raw = iret_i ? (exc_ret_pc_i + XLEN'(4)) :
                         exc_i  ? EXC_PC : redirect_pc_i;
    assign w_flush_pc  = w_flush_raw & ALIGN_MASK;
    assign w_bp_target = bp_target_i & ALIGN_MASK;
    assign w_pc_plus4  = r_pc + XLEN'(4);

    // Slot reservation: queued entries plus the in-flight response must fit, so a push can never overflow.
    assign w_outstanding = (r_state != ST_IDLE);
    assign w_has_room    = (w_count + {{(CW-1){1'b0}}, w_outstanding}) < CW'(DEPTH);
    assign w_issue       = (r_state == ST_IDLE) && !stall_i && !w_flush && w_has_room;

    assign w_push = (r_state == ST_WAIT) && imem_ack_i && !w_flush;
    assign w_pop  = out_valid_o && out_ready_i;

    assign w_push_dat.pc    = r_pc;
    assign w_push_dat.instr = imem_data_i;
    assign w_push_dat.pred  = r_bp_taken;

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            r_state     <= ST_IDLE;
            r_pc        <= RESET_PC;
            r_bp_taken  <= 1'b0;
            r_bp_target <= '0;
        end else if (w_flush) begin
            r_pc <= w_flush_pc;
            // A request still in flight must have its response swallowed before issuing again.
            if ((r_state != ST_IDLE) && !imem_ack_i) begin
                r_state <= ST_DRAIN;
            end else begin
                r_state <= ST_IDLE;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_issue) begin
                        r_state     <= ST_WAIT;
                        r_bp_taken  <= bp_taken_i;
                        r_bp_target <= w_bp_target;
                    end
                end
                ST_WAIT: begin
                    if (imem_ack_i) begin
                        r_state <= ST_IDLE;
                        r_pc    <= r_bp_taken ? r_bp_target : w_pc_plus4;
                    end
                end
                ST_DRAIN: begin
                    if (imem_ack_i) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    fetch_queue #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_queue (
        .clk_i      (clk_i),
        .rsn_i      (rsn_i),
        .push_i     (w_push),
        .push_dat_i (w_push_dat),
        .pop_i      (w_pop),
        .flush_i    (w_flush),
        .head_o     (w_head),
        .empty_o    (w_empty),
        .count_o    (w_count)
    );

    assign pc_o        = r_pc;
    assign imem_req_o  = (r_state == ST_WAIT);
    assign imem_addr_o = r_pc;

    // Queue storage is not reset, so the head is masked whenever nothing is valid.
    assign out_valid_o = !w_empty;
    assign out_pc_o    = w_empty ? '0 : w_head.pc;
    assign out_instr_o = w_empty ? '0 : w_head.instr;
    assign out_pred_o  = w_empty ? 1'b0 : w_head.pred;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios push expected requests/outputs,
// negedge monitors pop and compare; a small memory model answers requests with a set latency.
module tb_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rsn_i = 1'b0;
    logic        stall_i = 1'b1;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        exc_i = 1'b0;
    logic        iret_i = 1'b0;
    logic [31:0] exc_ret_pc_i = '0;
    logic [31:0] pc_o;
    logic        bp_taken_i;
    logic [31:0] bp_target_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_data_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b1;
    logic [31:0] out_pc_o;
    logic [31:0] out_instr_o;
    logic        out_pred_o;

    fetch_unit dut (
        .clk_i         (clk_i),
        .rsn_i         (rsn_i),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .exc_i         (exc_i),
        .iret_i        (iret_i),
        .exc_ret_pc_i  (exc_ret_pc_i),
        .pc_o          (pc_o),
        .bp_taken_i    (bp_taken_i),
        .bp_target_i   (bp_target_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_data_i   (imem_data_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_pc_o      (out_pc_o),
        .out_instr_o   (out_instr_o),
        .out_pred_o    (out_pred_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pred;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    exp_t        exp_out_q [$];
    logic [31:0] exp_addr_q [$];
    int          req_rises = 0;

    // Predictor stub: taken only for one chosen PC.
    logic        bp_en = 1'b0;
    logic [31:0] bp_pc = 32'h0000_1004;
    assign bp_taken_i  = bp_en && (pc_o == bp_pc);
    assign bp_target_i = 32'h0000_2003;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_fetch(input logic [31:0] a, input logic pred, input bit with_out);
        exp_t e;
        exp_addr_q.push_back(a);
        if (with_out) begin
            e.pc    = a;
            e.instr = mem_word(a);
            e.pred  = pred;
            exp_out_q.push_back(e);
        end
    endtask

    // Memory model: answers a request after mem_lat cycles, even if the request was withdrawn.
    int          mem_lat = 1;
    bit          mem_pend = 1'b0;
    logic [31:0] mem_addr = '0;
    int          mem_cnt = 0;
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            imem_ack_i = 1'b0;
            if (!rsn_i) begin
                mem_pend = 1'b0;
            end else if (mem_pend) begin
                if (mem_cnt <= 1) begin
                    imem_ack_i  = 1'b1;
                    imem_data_i = mem_word(mem_addr);
                    mem_pend    = 1'b0;
                end else begin
                    mem_cnt--;
                end
            end else if (imem_req_o) begin
                mem_pend = 1'b1;
                mem_addr = imem_addr_o;
                mem_cnt  = mem_lat;
            end
        end
    end

    // Request monitor: each new request must match the next expected address and hold it.
    logic        prev_req = 1'b0;
    logic [31:0] cur_exp_addr = '0;
    always @(negedge clk_i) begin
        if (!rsn_i) begin
            prev_req = 1'b0;
        end else begin
            if (imem_req_o && !prev_req) begin
                req_rises++;
                if (exp_addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: got addr %h, none expected at %0t", imem_addr_o, $time);
                end else begin
                    cur_exp_addr = exp_addr_q.pop_front();
                    check("req_addr", imem_addr_o, cur_exp_addr);
                end
            end else if (imem_req_o && prev_req) begin
                check("req_addr_hold", imem_addr_o, cur_exp_addr);
            end
            prev_req = imem_req_o;
        end
    end

    // Output monitor: every accepted entry must be the oldest expected one.
    exp_t mon_e;
    always @(negedge clk_i) begin
        if (rsn_i && out_valid_o && out_ready_i) begin
            if (exp_out_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got pc %h instr %h, none expected at %0t", out_pc_o, out_instr_o, $time);
            end else begin
                mon_e = exp_out_q.pop_front();
                check("out_pc", out_pc_o, mon_e.pc);
                check("out_instr", out_instr_o, mon_e.instr);
                check("out_pred", {31'b0, out_pred_o}, {31'b0, mon_e.pred});
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Let fetch run until n new requests have appeared, then stall further issue.
    task automatic fetch_n(input int n);
        int   seen = 0;
        int   cyc = 0;
        logic prev = imem_req_o;
        stall_i = 1'b0;
        while (seen < n && cyc < 200) begin
            tick();
            cyc++;
            if (imem_req_o && !prev) seen++;
            prev = imem_req_o;
        end
        stall_i = 1'b1;
        checks++;
        if (seen < n) begin
            errors++;
            $display("FAIL fetch_timeout: got %0d requests expected %0d", seen, n);
        end
    endtask

    task automatic wait_drain();
        int cyc = 0;
        while ((exp_out_q.size() != 0 || exp_addr_q.size() != 0 || imem_req_o || mem_pend) && cyc < 300) begin
            tick();
            cyc++;
        end
        checks++;
        if (cyc >= 300) begin
            errors++;
            $display("FAIL drain_timeout: got %0d outputs %0d requests pending, expected 0", exp_out_q.size(), exp_addr_q.size());
        end
        repeat (2) tick();
    endtask

    task automatic pulse_redirect(input logic [31:0] a);
        redirect_i    = 1'b1;
        redirect_pc_i = a;
        tick();
        redirect_i    = 1'b0;
    endtask

    int base;

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_pc", pc_o, 32'h0000_1000);
        check("rst_req", {31'b0, imem_req_o}, 32'd0);
        check("rst_valid", {31'b0, out_valid_o}, 32'd0);
        check("rst_out_pc", out_pc_o, 32'd0);
        rsn_i = 1'b1;
        tick();

        // Sequential fetch, ack latency 1, decode always ready
        expect_fetch(32'h0000_1000, 1'b0, 1'b1);
        expect_fetch(32'h0000_1004, 1'b0, 1'b1);
        expect_fetch(32'h0000_1008, 1'b0, 1'b1);
        fetch_n(3);
        wait_drain();

        // Decode blocked: exactly DEPTH requests, then one more after a single pop
        out_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) expect_fetch(32'h0000_100C + 32'(4 * i), 1'b0, 1'b1);
        base = req_rises;
        stall_i = 1'b0;
        repeat (40) tick();
        check("full_req_count", 32'(req_rises - base), 32'd4);
        check("full_req_idle", {31'b0, imem_req_o}, 32'd0);
        check("full_head_pc", out_pc_o, 32'h0000_100C);
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        repeat (10) tick();
        check("refill_req_count", 32'(req_rises - base), 32'd5);
        stall_i = 1'b1;
        out_ready_i = 1'b1;
        wait_drain();

        // Predicted-taken branch at 0x1004 to a misaligned target
        pulse_redirect(32'h0000_1000);
        bp_en = 1'b1;
        expect_fetch(32'h0000_1000, 1'b0, 1'b1);
        expect_fetch(32'h0000_1004, 1'b1, 1'b1);
        expect_fetch(32'h0000_2000, 1'b0, 1'b1);
        fetch_n(3);
        bp_en = 1'b0;
        wait_drain();

        // Redirect while waiting on a slow response: the late response must be dropped
        mem_lat = 3;
        expect_fetch(32'h0000_2004, 1'b0, 1'b0);
        fetch_n(1);
        pulse_redirect(32'h0000_3000);
        check("drain_req_low", {31'b0, imem_req_o}, 32'd0);
        check("drain_pc", pc_o, 32'h0000_3000);
        repeat (4) tick();
        check("stale_dropped", {31'b0, out_valid_o}, 32'd0);
        expect_fetch(32'h0000_3000, 1'b0, 1'b1);
        expect_fetch(32'h0000_3004, 1'b0, 1'b1);
        fetch_n(2);
        wait_drain();
        mem_lat = 1;

        // iret beats exc in the same cycle; then exc alone
        exc_i = 1'b1;
        iret_i = 1'b1;
        exc_ret_pc_i = 32'h0000_1010;
        tick();
        exc_i = 1'b0;
        iret_i = 1'b0;
        expect_fetch(32'h0000_1014, 1'b0, 1'b1);
        fetch_n(1);
        wait_drain();
        exc_i = 1'b1;
        tick();
        exc_i = 1'b0;
        expect_fetch(32'h0000_2000, 1'b0, 1'b1);
        fetch_n(1);
        wait_drain();

        // PC wraps around the top of the address space
        pulse_redirect(32'hFFFF_FFFC);
        expect_fetch(32'hFFFF_FFFC, 1'b0, 1'b1);
        expect_fetch(32'h0000_0000, 1'b0, 1'b1);
        fetch_n(2);
        wait_drain();

        // Asynchronous reset mid-request with two entries queued
        pulse_redirect(32'h0000_5000);
        out_ready_i = 1'b0;
        mem_lat = 3;
        expect_fetch(32'h0000_5000, 1'b0, 1'b0);
        expect_fetch(32'h0000_5004, 1'b0, 1'b0);
        expect_fetch(32'h0000_5008, 1'b0, 1'b0);
        fetch_n(3);
        check("pre_rst_req", {31'b0, imem_req_o}, 32'd1);
        check("pre_rst_head", out_pc_o, 32'h0000_5000);
        @(posedge clk_i);
        #2;
        rsn_i = 1'b0;
        #1;
        check("arst_valid", {31'b0, out_valid_o}, 32'd0);
        check("arst_req", {31'b0, imem_req_o}, 32'd0);
        check("arst_out_pc", out_pc_o, 32'd0);
        check("arst_out_instr", out_instr_o, 32'd0);
        check("arst_out_pred", {31'b0, out_pred_o}, 32'd0);
        check("arst_pc", pc_o, 32'h0000_1000);
        repeat (2) tick();
        rsn_i = 1'b1;
        mem_lat = 1;
        out_ready_i = 1'b1;
        tick();
        expect_fetch(32'h0000_1000, 1'b0, 1'b1);
        expect_fetch(32'h0000_1004, 1'b0, 1'b1);
        fetch_n(2);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter XLEN, 32, address/PC width.
REQ-002 Parameter RESET_PC, 32'h1000, PC after reset.
REQ-003 Parameter EXC_PC, 32'h2000, exception handler PC.
REQ-004 Parameter DEPTH, 4, fetch queue entries (power of 2, >=2).
REQ-005 clk_i  in  1  single clock, all state on rising edge.
REQ-006 rsn_i  in  1  reset, asynchronous, active-low.
REQ-007 stall_i  in  1  blocks issue of new memory requests.
REQ-008 redirect_i  in  1 / redirect_pc_i  in  XLEN  branch-mispredict correction.
REQ-009 exc_i  in  1  exception taken; iret_i  in  1 / exc_ret_pc_i  in  XLEN  return from exception.
REQ-010 pc_o  out  XLEN  current fetch PC, driven to the branch predictor.
REQ-011 bp_taken_i  in  1 / bp_target_i  in  XLEN  predictor result for pc_o, same cycle.
REQ-012 imem_req_o  out  1 / imem_addr_o  out  XLEN  instruction memory request.
REQ-013 imem_ack_i  in  1 / imem_data_i  in  32  response; latency >=1 cycle after request.
REQ-014 out_valid_o  out  1 / out_ready_i  in  1  decode handshake; out_pc_o XLEN, out_instr_o 32, out_pred_o 1.

Function
REQ-015 Flush priority, same cycle: iret_i -> exc_ret_pc_i+4, else exc_i -> EXC_PC, else redirect_i -> redirect_pc_i; flushes act regardless of stall_i.
REQ-016 Any flush empties the queue and loads pc next edge; out_valid_o low the following cycle.
REQ-017 FSM states IDLE, WAIT, DRAIN; one request outstanding maximum.
REQ-018 IDLE->WAIT when !stall_i, no flush, and (occupancy+outstanding) < DEPTH; bp_taken_i/bp_target_i sampled at that edge.
REQ-019 In WAIT imem_req_o=1, imem_addr_o=pc, both stable until imem_ack_i sampled high.
REQ-020 WAIT+ack, no flush: push {pc, imem_data_i, sampled taken}; pc <= taken ? target : pc+4; ->IDLE.
REQ-021 WAIT+flush without ack: ->DRAIN, imem_req_o=0; next ack discarded, ->IDLE.
REQ-022 WAIT+flush with ack same cycle: response discarded, ->IDLE directly.
REQ-023 Queue push and pop in same cycle allowed at any occupancy; overflow impossible by REQ-018 reservation.
REQ-024 Pop when out_valid_o && out_ready_i; out_* show oldest entry, stable while !out_ready_i.
REQ-025 PC arithmetic modulo 2^XLEN; pc+4 wraps to 0 from all-ones-minus-3.
REQ-026 Bits [1:0] of every loaded target forced to 0.

Reset
REQ-027 rsn_i low asynchronously: pc=RESET_PC, state IDLE, queue empty, imem_req_o=0, out_valid_o=0, out_pc_o/out_instr_o/out_pred_o=0.
REQ-028 Reset mid-WAIT abandons request; acks while in reset or in first IDLE cycle ignored.

Structure
REQ-029 Package fetch_pkg holds XLEN, RESET_PC, EXC_PC defaults, FSM state enum, queue entry typedef {pc, instr, pred}.
REQ-030 One sub-module fetch_queue: DEPTH-entry FIFO with push, pop, flush, count.

Verification
REQ-031 Reset release, ack latency 1, ready=1: requests 0x1000,0x1004,0x1008 in order; out_pc_o matches.
REQ-032 ready=0: exactly DEPTH=4 requests issued, then imem_req_o stays 0 until one pop.
REQ-033 bp_taken_i=1, target 0x2003 at pc 0x1004: next request address 0x2000, out_pred_o=1 on 0x1004 entry.
REQ-034 redirect_i to 0x3000 while WAIT, ack 3 cycles later: stale data never on out_*; next request 0x3000.
REQ-035 exc_i and iret_i same cycle, exc_ret_pc_i=0x1010: next request 0x1014; exc_i alone -> 0x2000.
REQ-036 rsn_i pulsed low mid-WAIT with queue 2 full: all outputs zero immediately, restart fetch at 0x1000.
